// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the round-robin arbitrating mux.
// Build option: MUX_ARB_SKID_EN selects the two-entry skid output buffer.
package mux_arb_pkg;

    localparam int MAX_CHANNELS = 16;
    localparam int SKID_DEPTH   = 2;

    function automatic int sel_nbits(input int n);
        return $clog2(n);
    endfunction

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/rr_arb_rtl.sv
// Round-robin arbiter: grant scans from ptr, ptr moves past an accepted grant.
// ptr only advances when en is high and a request is granted.
module rr_arb_rtl
    import mux_arb_pkg::*;
#(
    parameter int p_nreqs = 4,
    localparam int SW = sel_nbits(p_nreqs)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [p_nreqs-1:0] req,
    input  logic               en,
    output logic [p_nreqs-1:0] grant,
    output logic [SW-1:0]      grant_idx
);

    logic [SW-1:0] ptr;
    logic          found;
    logic [SW-1:0] idx;

    // first requester at or after ptr, wrapping
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < p_nreqs; k++) begin
            idx = SW'((int'(ptr) + k) % p_nreqs);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    // pointer moves to the channel after the accepted one
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (en && found) begin
            if (grant_idx == SW'(p_nreqs - 1))
                ptr <= '0;
            else
                ptr <= grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mux_arb_rtl.sv
// N-channel arbitrating mux with registered, source-tagged output.
// Build option: MUX_ARB_SKID_EN (two-entry skid buffer, no out_rdy->in_rdy path).
module mux_arb_rtl
    import mux_arb_pkg::*;
#(
    parameter int p_nchannels = 4,
    parameter int p_nbits     = 32,
    localparam int SW = sel_nbits(p_nchannels)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [p_nchannels-1:0]         in_val,
    input  logic [p_nchannels*p_nbits-1:0] in_msg,
    output logic [p_nchannels-1:0]         in_rdy,
    output logic                           out_val,
    output logic [p_nbits-1:0]             out_msg,
    output logic [SW-1:0]                  out_sel,
    input  logic                           out_rdy
);

    typedef struct packed {
        logic [p_nbits-1:0] msg;
        logic [SW-1:0]      sel;
    } ent_t;

    logic [p_nchannels-1:0] grant;
    logic [SW-1:0]          grant_idx;
    logic                   can_accept;
    logic                   enq;
    logic                   deq;
    logic [p_nbits-1:0]     ch_msg [p_nchannels];
    ent_t                   new_ent;
    ent_t                   head;

    for (genvar i = 0; i < p_nchannels; i++) begin : g_split
        assign ch_msg[i] = in_msg[i*p_nbits +: p_nbits];
    end

    rr_arb_rtl #(
        .p_nreqs (p_nchannels)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (in_val),
        .en        (can_accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign in_rdy  = grant & {p_nchannels{can_accept & reset}};
    assign enq     = |in_rdy;
    assign deq     = out_val & out_rdy;
    assign new_ent = '{msg: ch_msg[grant_idx], sel: grant_idx};
    assign out_msg = head.msg;
    assign out_sel = head.sel;

`ifdef MUX_ARB_SKID_EN
    occ_t occ;
    ent_t skid;

    assign can_accept = (occ != occ_t'(SKID_DEPTH));
    assign out_val    = (occ != 2'd0);

    // head feeds the output; skid catches one message during a stall
    always_ff @(posedge clk) begin
        if (!reset) begin
            occ  <= '0;
            head <= '0;
            skid <= '0;
        end else begin
            if (enq && (occ == 2'd0 || (occ == 2'd1 && deq)))
                head <= new_ent;
            if (enq && occ == 2'd1 && !deq)
                skid <= new_ent;
            if (deq && occ == 2'd2)
                head <= skid;
            occ <= occ + {1'b0, enq} - {1'b0, deq};
        end
    end
`else
    logic full;

    assign can_accept = !full | out_rdy;
    assign out_val    = full;

    // single output register, refilled in the same cycle it drains
    always_ff @(posedge clk) begin
        if (!reset) begin
            full <= 1'b0;
            head <= '0;
        end else if (enq) begin
            full <= 1'b1;
            head <= new_ent;
        end else if (out_rdy) begin
            full <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mux_arb_rtl.sv
// Self-checking bench for mux_arb_rtl (4 channels, 8-bit messages).
// Reference model: round-robin pointer plus scoreboard queue of accepted messages.
module tb_mux_arb_rtl;

`ifdef MUX_ARB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int N = 4;
    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic [N-1:0] in_val;
    logic [N*W-1:0] in_msg;
    logic [N-1:0] in_rdy;
    logic         out_val;
    logic [W-1:0] out_msg;
    logic [1:0]   out_sel;
    logic         out_rdy;

    mux_arb_rtl #(.p_nchannels(N), .p_nbits(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_msg  (in_msg),
        .in_rdy  (in_rdy),
        .out_val (out_val),
        .out_msg (out_msg),
        .out_sel (out_sel),
        .out_rdy (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] msg;
        logic [1:0]   sel;
    } ent_t;

    typedef struct {
        logic         rst_n;
        logic [N-1:0] val;
        logic [N*W-1:0] msg;
        logic         ordy;
        bit           chk;
        logic [N-1:0] e_rdy;
        logic         e_val;
        logic [W-1:0] e_msg;
        logic [1:0]   e_sel;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    ent_t q[$];
    logic [1:0] mptr = 2'd0;
    ent_t last = '{msg: 8'h00, sel: 2'd0};
    int   wait_cnt [N];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [N-1:0] v,
                                input logic [N*W-1:0] m, input logic o);
        vec_t x;
        x = '{rst_n: r, val: v, msg: m, ordy: o, chk: 1'b0,
              e_rdy: '0, e_val: 1'b0, e_msg: '0, e_sel: '0};
        return x;
    endfunction

    function automatic vec_t mkx(input logic r, input logic [N-1:0] v,
                                 input logic [N*W-1:0] m, input logic o,
                                 input logic [N-1:0] er, input logic ev,
                                 input logic [W-1:0] em, input logic [1:0] es);
        vec_t x;
        x = '{rst_n: r, val: v, msg: m, ordy: o, chk: 1'b1,
              e_rdy: er, e_val: ev, e_msg: em, e_sel: es};
        return x;
    endfunction

    task automatic step(input vec_t v);
        logic [N-1:0] g;
        logic [1:0]   gi;
        logic         found;
        logic         can;
        logic [N-1:0] er;
        logic [7:0]   tmp;
        logic [W-1:0] chm;
        ent_t         hd;
        reset   = v.rst_n;
        in_val  = v.val;
        in_msg  = v.msg;
        out_rdy = v.ordy;
        g = '0; gi = '0; found = 1'b0;
        for (int k = 0; k < N; k++) begin
            tmp = 8'((int'(mptr) + k) % N);
            if (!found && v.val[tmp[1:0]]) begin
                found = 1'b1;
                gi = tmp[1:0];
                g[gi] = 1'b1;
            end
        end
        can = SKID ? (q.size() < 2) : (q.size() == 0 || v.ordy);
        er  = (v.rst_n && can) ? g : '0;
        hd  = (q.size() != 0) ? q[0] : last;
        @(negedge clk);
        chk("in_rdy", 32'(in_rdy), 32'(er));
        chk("out_val", 32'(out_val), 32'(q.size() != 0));
        chk("out_msg", 32'(out_msg), 32'(hd.msg));
        chk("out_sel", 32'(out_sel), 32'(hd.sel));
        chk("ptr", 32'(dut.u_arb.ptr), 32'(mptr));
        if (v.chk) begin
            chk("tab_in_rdy", 32'(in_rdy), 32'(v.e_rdy));
            chk("tab_out_val", 32'(out_val), 32'(v.e_val));
            chk("tab_out_msg", 32'(out_msg), 32'(v.e_msg));
            chk("tab_out_sel", 32'(out_sel), 32'(v.e_sel));
        end
        @(posedge clk);
        if (!v.rst_n) begin
            q.delete();
            mptr = 2'd0;
            last = '{msg: 8'h00, sel: 2'd0};
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else begin
            if (q.size() != 0 && v.ordy) void'(q.pop_front());
            if (|er) begin
                chm = v.msg[gi*W +: W];
                q.push_back('{msg: chm, sel: gi});
                mptr = (gi == 2'd3) ? 2'd0 : gi + 2'd1;
                for (int i = 0; i < N; i++) begin
                    if (!v.val[i] || i == int'(gi)) wait_cnt[i] = 0;
                    else wait_cnt[i]++;
                    chk("fairness", 32'(wait_cnt[i] <= N - 1), 32'd1);
                end
            end else begin
                for (int i = 0; i < N; i++)
                    if (!v.val[i]) wait_cnt[i] = 0;
            end
            if (q.size() != 0) last = q[0];
        end
        #1;
    endtask

    vec_t tv[9];
    localparam logic [N*W-1:0] RR = 32'hA3A2A1A0;

    initial begin
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        reset = 1'b0; in_val = '0; in_msg = '0; out_rdy = 1'b0;
        tv[0] = mkx(0, 4'b1111, RR, 1, 4'b0000, 0, 8'h00, 2'd0);
        tv[1] = mkx(0, 4'b1111, RR, 1, 4'b0000, 0, 8'h00, 2'd0);
        tv[2] = mkx(1, 4'b1111, RR, 1, 4'b0001, 0, 8'h00, 2'd0);
        tv[3] = mkx(1, 4'b1111, RR, 1, 4'b0010, 1, 8'hA0, 2'd0);
        tv[4] = mkx(1, 4'b1111, RR, 1, 4'b0100, 1, 8'hA1, 2'd1);
        tv[5] = mkx(1, 4'b1111, RR, 1, 4'b1000, 1, 8'hA2, 2'd2);
        tv[6] = mkx(1, 4'b1111, RR, 1, 4'b0001, 1, 8'hA3, 2'd3);
        tv[7] = mkx(1, 4'b0000, RR, 1, 4'b0000, 1, 8'hA0, 2'd0);
        tv[8] = mkx(1, 4'b0000, RR, 1, 4'b0000, 0, 8'hA0, 2'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) step(tv[i]);

        // wrap and skip: ptr reaches 3, then 0101 grants ch0 then ch2
        step(mk(0, 4'b0000, '0, 1));
        step(mkx(1, 4'b0100, 32'h00330000, 1, 4'b0100, 0, 8'h00, 2'd0));
        step(mkx(1, 4'b0101, 32'h00220011, 1, 4'b0001, 1, 8'h33, 2'd2));
        step(mkx(1, 4'b0101, 32'h00220011, 1, 4'b0100, 1, 8'h11, 2'd0));
        step(mkx(1, 4'b0000, 32'h0, 1, 4'b0000, 1, 8'h22, 2'd2));

        // backpressure holding 5C from ch2
        step(mk(0, 4'b0000, '0, 1));
        step(mkx(1, 4'b0100, 32'h005C0000, 0, 4'b0100, 0, 8'h00, 2'd0));
        step(mkx(1, 4'b1111, RR, 0, SKID ? 4'b1000 : 4'b0000,
                 1, 8'h5C, 2'd2));
        step(mkx(1, 4'b1111, RR, 0, 4'b0000, 1, 8'h5C, 2'd2));
        step(mkx(1, 4'b1111, RR, 0, 4'b0000, 1, 8'h5C, 2'd2));
        step(mkx(1, 4'b0000, RR, 1, 4'b0000, 1, 8'h5C, 2'd2));
        step(mkx(1, 4'b0000, RR, 1, 4'b0000, SKID, SKID ? 8'hA3 : 8'h5C,
                 SKID ? 2'd3 : 2'd2));
        step(mk(1, 4'b0000, RR, 1));

        // mid-operation reset drops buffered 77
        step(mk(1, 4'b0010, 32'h00007700, 0));
        step(mkx(1, 4'b0000, '0, 0, 4'b0000, 1, 8'h77, 2'd1));
        step(mk(0, 4'b0000, '0, 0));
        step(mkx(1, 4'b0000, '0, 1, 4'b0000, 0, 8'h00, 2'd0));
        step(mk(1, 4'b0000, '0, 1));

        // random traffic against the model
        for (int c = 0; c < 500; c++) begin
            step(mk(1, 4'($urandom_range(0, 15)), 32'($urandom),
                    1'($urandom_range(0, 3) != 0)));
        end
        for (int c = 0; c < 4; c++) step(mk(1, 4'b0000, '0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
